// File: rtl/gfx_pkg.sv
// Shared constants, encodings and types for the sprite blitter.
package gfx_pkg;

    localparam int DEF_FB_W      = 160;
    localparam int DEF_FB_H      = 120;
    localparam int DEF_FB_ADDR_W = 19;

    typedef enum logic [1:0] {
        MODE_COPY  = 2'b00,
        MODE_OR    = 2'b01,
        MODE_XOR   = 2'b10,
        MODE_CLEAR = 2'b11
    } blit_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_ISSUE,
        ST_WRITE,
        ST_DONE
    } blit_state_t;

    // Request fields captured at acceptance; dst_base lives beside it
    // because its width follows the framebuffer address parameter.
    typedef struct packed {
        logic       size;
        blit_mode_t mode;
        logic [7:0] src_base;
        logic [7:0] dst_x;
        logic [6:0] dst_y;
    } blit_req_t;

    // Raster-op combining a sprite pixel with the existing framebuffer pixel.
    function automatic logic blend(input blit_mode_t mode, input logic src, input logic fb);
        case (mode)
            MODE_COPY: return src;
            MODE_OR:   return fb | src;
            MODE_XOR:  return fb ^ src;
            default:   return fb & ~src;
        endcase
    endfunction

endpackage

// File: rtl/gmem_blitter_if.sv
// Memory-side bus of the blitter: sprite ROM read port and framebuffer
// read/write port, both with one-cycle read latency.
interface gmem_bus_if
    import gfx_pkg::*;
#(
    parameter int FB_ADDR_W = DEF_FB_ADDR_W
);
    logic [7:0]           src_addr;
    logic                 src_data;
    logic [FB_ADDR_W-1:0] fb_addr;
    logic                 fb_wdata;
    logic                 fb_rdata;
    logic                 fb_wen;

    modport master (
        output src_addr,
        output fb_addr,
        output fb_wdata,
        output fb_wen,
        input  src_data,
        input  fb_rdata
    );

    modport slave (
        input  src_addr,
        input  fb_addr,
        input  fb_wdata,
        input  fb_wen,
        output src_data,
        output fb_rdata
    );
endinterface

// File: rtl/gmem_blitter_addr_gen.sv
// Combinational address generation and clipping for one sprite pixel.
module blit_addr_gen
    import gfx_pkg::*;
#(
    parameter int FB_W      = DEF_FB_W,
    parameter int FB_H      = DEF_FB_H,
    parameter int FB_ADDR_W = DEF_FB_ADDR_W
) (
    input  logic [3:0]           row,
    input  logic [3:0]           col,
    input  logic                 size,
    input  logic [7:0]           src_base,
    input  logic [7:0]           dst_x,
    input  logic [6:0]           dst_y,
    input  logic [FB_ADDR_W-1:0] dst_base,
    output logic [7:0]           src_addr,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic                 clip
);
    logic [8:0] px;
    logic [7:0] py;
    logic [7:0] row_off;

    // Screen coordinates are widened by one bit so the right/bottom edge
    // test never wraps; the ROM address wraps naturally at 8 bits.
    always_comb begin
        px       = {1'b0, dst_x} + {5'b0, col};
        py       = {1'b0, dst_y} + {4'b0, row};
        row_off  = size ? {row, 4'b0} : {1'b0, row, 3'b0};
        src_addr = src_base + row_off + {4'b0, col};
        clip     = (px >= 9'(FB_W)) || (py >= 8'(FB_H));
        fb_addr  = dst_base + FB_ADDR_W'(px) + FB_ADDR_W'(FB_W) * FB_ADDR_W'(py);
    end
endmodule

// File: rtl/gmem_blitter.sv
// 1-bpp sprite blitter: reads an 8x8 or 16x16 sprite from ROM and combines
// it into the framebuffer, two cycles per pixel (address issue, then write).
module gmem_blitter
    import gfx_pkg::*;
#(
    parameter int FB_W      = DEF_FB_W,
    parameter int FB_H      = DEF_FB_H,
    parameter int FB_ADDR_W = DEF_FB_ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 size,
    input  logic [1:0]           mode,
    input  logic                 vsync_wait,
    input  logic                 frame_end,
    input  logic [7:0]           src_base,
    input  logic [7:0]           dst_x,
    input  logic [6:0]           dst_y,
    input  logic [FB_ADDR_W-1:0] dst_base,
    gmem_bus_if.master           bus,
    output logic                 busy,
    output logic                 done,
    output logic                 collide
);
    blit_state_t          state;
    blit_state_t          state_next;
    blit_req_t            req;
    logic [FB_ADDR_W-1:0] base;
    logic [3:0]           row;
    logic [3:0]           col;
    logic [3:0]           last_idx;
    logic                 last_col;
    logic                 last_pixel;
    logic                 accept;
    logic                 clip;
    logic                 wen;
    logic                 wdata;
    logic [7:0]           src_addr;
    logic [FB_ADDR_W-1:0] fb_addr;

    assign accept     = (state == ST_IDLE) && start;
    assign last_idx   = req.size ? 4'd15 : 4'd7;
    assign last_col   = (col == last_idx);
    assign last_pixel = last_col && (row == last_idx);

    // Addresses depend only on registered row/col and the latched request,
    // so they are stable through ISSUE and WRITE of each pixel.
    blit_addr_gen #(
        .FB_W      (FB_W),
        .FB_H      (FB_H),
        .FB_ADDR_W (FB_ADDR_W)
    ) u_addr_gen (
        .row      (row),
        .col      (col),
        .size     (req.size),
        .src_base (req.src_base),
        .dst_x    (req.dst_x),
        .dst_y    (req.dst_y),
        .dst_base (base),
        .src_addr (src_addr),
        .fb_addr  (fb_addr),
        .clip     (clip)
    );

    assign bus.src_addr = src_addr;
    assign bus.fb_addr  = fb_addr;
    assign bus.fb_wen   = wen;
    assign bus.fb_wdata = wdata;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus status and write-strobe outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        wen        = 1'b0;
        wdata      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = vsync_wait ? ST_SYNC : ST_ISSUE;
                end
            end
            ST_SYNC: begin
                if (frame_end) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = ST_WRITE;
            end
            ST_WRITE: begin
                wen        = !clip;
                wdata      = blend(req.mode, bus.src_data, bus.fb_rdata);
                state_next = last_pixel ? ST_DONE : ST_ISSUE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Request latch, raster counters and collision flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            req     <= '0;
            base    <= '0;
            row     <= '0;
            col     <= '0;
            collide <= 1'b0;
        end else begin
            if (accept) begin
                req.size     <= size;
                req.mode     <= blit_mode_t'(mode);
                req.src_base <= src_base;
                req.dst_x    <= dst_x;
                req.dst_y    <= dst_y;
                base         <= dst_base;
                row          <= '0;
                col          <= '0;
                collide      <= 1'b0;
            end
            if (state == ST_WRITE) begin
                if (!clip && bus.src_data && bus.fb_rdata) begin
                    collide <= 1'b1;
                end
                if (last_pixel) begin
                    row <= '0;
                    col <= '0;
                end else if (last_col) begin
                    row <= row + 4'd1;
                    col <= '0;
                end else begin
                    col <= col + 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_gmem_blitter.sv
// Scoreboard bench for gmem_blitter: a pixel-level reference model predicts
// every framebuffer write and each done pulse; a monitor checks them.
module tb_gmem_blitter;
    import gfx_pkg::*;

    localparam int FB_W      = 160;
    localparam int FB_H      = 120;
    localparam int FB_ADDR_W = 19;
    localparam int MEM_SZ    = 1 << FB_ADDR_W;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic                 size = 1'b0;
    logic [1:0]           mode = 2'b00;
    logic                 vsync_wait = 1'b0;
    logic                 frame_end = 1'b0;
    logic [7:0]           src_base = '0;
    logic [7:0]           dst_x = '0;
    logic [6:0]           dst_y = '0;
    logic [FB_ADDR_W-1:0] dst_base = '0;
    logic                 busy;
    logic                 done;
    logic                 collide;

    gmem_bus_if #(.FB_ADDR_W(FB_ADDR_W)) bus ();

    gmem_blitter #(
        .FB_W      (FB_W),
        .FB_H      (FB_H),
        .FB_ADDR_W (FB_ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .size       (size),
        .mode       (mode),
        .vsync_wait (vsync_wait),
        .frame_end  (frame_end),
        .src_base   (src_base),
        .dst_x      (dst_x),
        .dst_y      (dst_y),
        .dst_base   (dst_base),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .collide    (collide)
    );

    always #5 clk = ~clk;

    bit rom    [256];
    bit fb_mem [MEM_SZ];
    bit ref_fb [MEM_SZ];
    int cyc = 0;

    // Sprite ROM and framebuffer with one-cycle read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        bus.src_data <= rom[bus.src_addr];
        bus.fb_rdata <= fb_mem[bus.fb_addr];
        if (bus.fb_wen) fb_mem[bus.fb_addr] <= bus.fb_wdata;
    end

    typedef struct { int addr; bit data; } wr_t;
    typedef struct { int done_cyc; bit coll; int nwr; } dn_t;

    wr_t wr_q[$];
    dn_t dn_q[$];
    int  checks = 0;
    int  fails = 0;
    int  wr_seen = 0;
    int  first_wr_addr = -1;
    bit  vs_block = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop expected writes and done records as the DUT presents them.
    initial begin
        wr_t we;
        dn_t de;
        forever begin
            @(negedge clk);
            if (reset) begin
                wr_seen = 0;
            end else begin
                if (vs_block) check("no_write_before_frame_end", bus.fb_wen, 0);
                if (bus.fb_wen) begin
                    if (wr_q.size() == 0) begin
                        check("unexpected_write_addr", bus.fb_addr, -1);
                    end else begin
                        we = wr_q.pop_front();
                        check("write_addr", bus.fb_addr, we.addr);
                        check("write_data", bus.fb_wdata, we.data);
                    end
                    if (wr_seen == 0) first_wr_addr = int'(bus.fb_addr);
                    wr_seen++;
                end
                if (done) begin
                    if (dn_q.size() == 0) begin
                        check("unexpected_done", done, 0);
                    end else begin
                        de = dn_q.pop_front();
                        check("done_cycle", cyc, de.done_cyc);
                        check("done_collide", collide, de.coll);
                        check("done_write_count", wr_seen, de.nwr);
                    end
                    wr_seen = 0;
                end
            end
        end
    end

    // Reference model: walk the sprite pixel by pixel in raster order.
    task automatic model_blit(input bit sz, input bit [1:0] md, input int sb, input int dx,
                              input int dy, input int db, input int npix,
                              output bit coll, output int nwr);
        int w;
        int r;
        int c;
        int x;
        int y;
        int a;
        bit s;
        bit f;
        bit n;
        w = sz ? 16 : 8;
        coll = 0;
        nwr = 0;
        for (int p = 0; p < npix; p++) begin
            r = p / w;
            c = p % w;
            x = dx + c;
            y = dy + r;
            s = rom[(sb + p) % 256];
            if (x < FB_W && y < FB_H) begin
                a = db + x + FB_W * y;
                f = ref_fb[a];
                case (md)
                    2'd0:    n = s;
                    2'd1:    n = f | s;
                    2'd2:    n = f ^ s;
                    default: n = f & ~s;
                endcase
                if (s && f) coll = 1;
                ref_fb[a] = n;
                wr_q.push_back('{a, n});
                nwr++;
            end
        end
    endtask

    // One blit: predict, drive the request, poke start while busy,
    // optionally deliver frame_end or abort with reset, then wait for idle.
    task automatic run_blit(input bit sz, input bit [1:0] md, input int sb, input int dx,
                            input int dy, input int db, input bit vs, input int fdelay,
                            input int abort_at);
        bit coll;
        int nwr;
        int c0;
        int lat;
        int npix;
        int guard;
        npix = sz ? 256 : 64;
        model_blit(sz, md, sb, dx, dy, db, (abort_at >= 0) ? abort_at : npix, coll, nwr);
        size = sz;
        mode = md;
        src_base = 8'(sb);
        dst_x = 8'(dx);
        dst_y = 7'(dy);
        dst_base = FB_ADDR_W'(db);
        vsync_wait = vs;
        start = 1'b1;
        c0 = cyc;
        lat = (vs ? fdelay + 1 : 1) + 2 * npix + 1;
        if (abort_at < 0) dn_q.push_back('{c0 + lat - 1, coll, nwr});
        if (vs) vs_block = 1;
        tick();
        start = 1'b0;
        size = ~sz;
        mode = ~md;
        src_base = 8'($urandom);
        dst_x = 8'($urandom);
        dst_y = 7'($urandom);
        dst_base = FB_ADDR_W'($urandom_range(0, 3) * 19200);
        vsync_wait = ~vs;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        if (vs) begin
            while (cyc < c0 + fdelay) tick();
            vs_block = 0;
            frame_end = 1'b1;
            tick();
            frame_end = 1'b0;
        end
        if (abort_at >= 0) begin
            while (cyc < c0 + 1 + 2 * abort_at) tick();
            reset = 1'b1;
            tick();
            reset = 1'b0;
            check("abort_busy", busy, 0);
            check("abort_fb_wen", bus.fb_wen, 0);
            check("abort_done", done, 0);
            for (int i = 0; i < 20; i++) tick();
            check("abort_pending_writes", wr_q.size(), 0);
        end
        guard = 0;
        while (busy && guard < 3000) begin
            tick();
            guard++;
        end
        check("blit_finished_in_time", guard < 3000, 1);
        tick();
    endtask

    initial begin
        int bad;
        int a;
        for (int i = 0; i < 256; i++) rom[i] = 1'($urandom);
        rom[0] = 1'b1;
        rom[37] = 1'b1;

        // Reset state.
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_collide", collide, 0);
        check("reset_fb_wen", bus.fb_wen, 0);
        check("reset_fb_wdata", bus.fb_wdata, 0);
        check("reset_fb_addr", bus.fb_addr, 0);
        check("reset_src_addr", bus.src_addr, 0);
        tick();

        // COPY 8x8 at (10,20) into a zero framebuffer.
        run_blit(0, 2'd0, 0, 10, 20, 0, 0, 0, -1);
        check("copy_first_addr", first_wr_addr, 3210);
        check("copy_collide", collide, 0);

        // XOR twice restores zero and the second pass collides.
        run_blit(0, 2'd2, 0, 10, 60, 0, 0, 0, -1);
        run_blit(0, 2'd2, 0, 10, 60, 0, 0, 0, -1);
        check("xor_twice_collide", collide, 1);
        bad = 0;
        for (int y = 60; y < 68; y++)
            for (int x = 10; x < 18; x++)
                if (fb_mem[x + FB_W * y] != 1'b0) bad++;
        check("xor_twice_region_zero", bad, 0);

        // 16x16 at the bottom-right corner: only an 8x8 part is visible.
        run_blit(1, 2'd0, 5, 152, 112, 19200, 0, 0, -1);

        // Vsync-gated blit with frame_end 50 cycles after start.
        run_blit(0, 2'd1, 9, 50, 5, 0, 1, 50, -1);

        // Abort at pixel 30, then redo the same blit to completion.
        run_blit(0, 2'd0, 3, 80, 30, 0, 0, 0, 30);
        run_blit(0, 2'd0, 3, 80, 30, 0, 0, 0, -1);

        // CLEAR over an all-ones patch erases exactly the sprite's 1-pixels.
        for (int y = 80; y < 88; y++)
            for (int x = 100; x < 108; x++) begin
                fb_mem[x + FB_W * y] = 1'b1;
                ref_fb[x + FB_W * y] = 1'b1;
            end
        run_blit(0, 2'd3, 37, 100, 80, 0, 0, 0, -1);
        bad = 0;
        for (int p = 0; p < 64; p++) begin
            a = (100 + p % 8) + FB_W * (80 + p / 8);
            if (fb_mem[a] != !rom[(37 + p) % 256]) bad++;
        end
        check("clear_region", bad, 0);

        // Randomized blits including clipping, pages, modes and vsync.
        for (int k = 0; k < 8; k++) begin
            run_blit(1'($urandom), 2'($urandom), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 175)), int'($urandom_range(0, 127)),
                     int'($urandom_range(0, 3)) * 19200, 1'($urandom),
                     int'($urandom_range(5, 60)), -1);
        end

        for (int i = 0; i < 5; i++) tick();
        check("final_write_queue_empty", wr_q.size(), 0);
        check("final_done_queue_empty", dn_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
